// File: rtl/key_debounce_if.sv
// Key conditioning bundle: raw pins in, debounced level, press/release pulses and encoded event out.
interface key_debounce_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic               key_event_valid;
    logic [2:0]         key_event_code;

    modport master (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_event_valid,
        output key_event_code
    );

    modport slave (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_event_valid,
        input  key_event_code
    );
endinterface

// File: rtl/key_debounce.sv
// Synchronise + debounce push-button pins into level, press/release pulses and an encoded key event.
// Latency DEBOUNCE_MAX_CNT+3 cycles pin-to-pulse (+1 for the event); no backpressure, pulses are fire-and-forget.
module key_debounce #(
    parameter int CLOCK_FREQ       = 50000000,
    parameter int DEBOUNCE_MS      = 20,
    parameter int DEBOUNCE_MAX_CNT = CLOCK_FREQ / 1000 * DEBOUNCE_MS - 1,
    parameter int KEY_NUM          = 4,
    parameter int KEY_ACTIVE_LOW   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debounce_if.master bus
);

    localparam int CNT_W = (DEBOUNCE_MAX_CNT > 1) ? $clog2(DEBOUNCE_MAX_CNT + 1) : 1;
    // The filter-entry edge is itself the first agreeing sample, so the window closes
    // after DEBOUNCE_MAX_CNT further counting edges (DEBOUNCE_MAX_CNT+1 samples total).
    localparam logic [CNT_W-1:0] CNT_TERM =
        CNT_W'((DEBOUNCE_MAX_CNT > 0) ? DEBOUNCE_MAX_CNT - 1 : 0);
    localparam logic [KEY_NUM-1:0] PIN_IDLE = {KEY_NUM{KEY_ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_DOWN_FILT = 2'd1,
        ST_DOWN      = 2'd2,
        ST_UP_FILT   = 2'd3
    } state_e;

    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;
    logic [KEY_NUM-1:0] pressed;

    state_e             state_q [KEY_NUM];
    state_e             state_d [KEY_NUM];
    logic [CNT_W-1:0]   cnt_q   [KEY_NUM];
    logic [CNT_W-1:0]   cnt_d   [KEY_NUM];

    logic [KEY_NUM-1:0] level_q,   level_d;
    logic [KEY_NUM-1:0] press_q,   press_d;
    logic [KEY_NUM-1:0] release_q, release_d;
    logic               evt_vld_q;
    logic [2:0]         evt_code_q, evt_code_d;

    // Synchroniser resets to the idle pin level so reset release never looks like a press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= bus.key_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_NUM; i++) begin
                state_q[i] <= ST_UP;
                cnt_q[i]   <= '0;
            end
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            evt_vld_q  <= 1'b0;
            evt_code_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            evt_vld_q  <= |press_q;
            evt_code_q <= evt_code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            case (state_q[i])
                ST_UP: begin
                    if (pressed[i]) begin
                        state_d[i] = ST_DOWN_FILT;
                        cnt_d[i]   = '0;
                    end
                end
                ST_DOWN_FILT: begin
                    if (!pressed[i]) begin
                        state_d[i] = ST_UP;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_TERM) begin
                        state_d[i] = ST_DOWN;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (!pressed[i]) begin
                        state_d[i] = ST_UP_FILT;
                        cnt_d[i]   = '0;
                    end
                end
                ST_UP_FILT: begin
                    if (pressed[i]) begin
                        state_d[i] = ST_DOWN;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_TERM) begin
                        state_d[i]   = ST_UP;
                        cnt_d[i]     = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_UP;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Lowest-index priority; the code holds between events.
    always_comb begin
        evt_code_d = evt_code_q;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                evt_code_d = 3'(i);
            end
        end
    end

    assign bus.key_level       = level_q;
    assign bus.key_press       = press_q;
    assign bus.key_release     = release_q;
    assign bus.key_event_valid = evt_vld_q;
    assign bus.key_event_code  = evt_code_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulses/events queued at stimulus time, matched as the DUT emits them.
module tb_key_debounce;

    localparam int MAX = 9;
    localparam int NK  = 4;
    localparam int LAT = MAX + 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    key_debounce_if #(.KEY_NUM(NK)) bus ();

    key_debounce #(
        .CLOCK_FREQ       (50000000),
        .DEBOUNCE_MS      (20),
        .DEBOUNCE_MAX_CNT (MAX),
        .KEY_NUM          (NK),
        .KEY_ACTIVE_LOW   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lvl;
    } pulse_t;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } evt_t;

    pulse_t pq[$];
    evt_t   eq[$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_press(input logic [NK-1:0] keys, input logic [NK-1:0] lvl_after,
                                input logic [2:0] code);
        pulse_t p;
        evt_t   e;
        p.cyc   = cyc + LAT;
        p.press = keys;
        p.rel   = '0;
        p.lvl   = lvl_after;
        e.cyc   = cyc + LAT + 1;
        e.code  = code;
        pq.push_back(p);
        eq.push_back(e);
    endtask

    task automatic expect_release(input logic [NK-1:0] keys, input logic [NK-1:0] lvl_after);
        pulse_t p;
        p.cyc   = cyc + LAT;
        p.press = '0;
        p.rel   = keys;
        p.lvl   = lvl_after;
        pq.push_back(p);
    endtask

    always @(negedge clk) begin
        pulse_t p;
        evt_t   e;
        if (bus.key_press != '0 || bus.key_release != '0) begin
            if (pq.size() == 0) begin
                chk("unexpected_pulse", 32'({bus.key_press, bus.key_release}), 32'd0);
            end else begin
                p = pq.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(p.cyc));
                chk("press", 32'(bus.key_press), 32'(p.press));
                chk("release", 32'(bus.key_release), 32'(p.rel));
                chk("level_at_pulse", 32'(bus.key_level), 32'(p.lvl));
            end
        end
        if (bus.key_event_valid === 1'b1) begin
            if (eq.size() == 0) begin
                chk("unexpected_event", 32'(bus.key_event_code), 32'hFFFF_FFFF);
            end else begin
                e = eq.pop_front();
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                chk("event_code", 32'(bus.key_event_code), 32'(e.code));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        bus.key_in = '1;
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(bus.key_level), 32'd0);
        chk("rst_press", 32'(bus.key_press), 32'd0);
        chk("rst_release", 32'(bus.key_release), 32'd0);
        chk("rst_evt_vld", 32'(bus.key_event_valid), 32'd0);
        chk("rst_evt_code", 32'(bus.key_event_code), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean press and release of key 0
        bus.key_in[0] = 1'b0;
        expect_press(4'b0001, 4'b0001, 3'd0);
        repeat (20) @(negedge clk);
        chk("t1_level", 32'(bus.key_level), 32'h1);
        bus.key_in[0] = 1'b1;
        expect_release(4'b0001, 4'b0000);
        repeat (20) @(negedge clk);

        // Short bounces on key 1 must be rejected
        for (int k = 0; k < 3; k++) begin
            bus.key_in[1] = 1'b0;
            repeat (5) @(negedge clk);
            bus.key_in[1] = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (15) @(negedge clk);
        chk("t2_level", 32'(bus.key_level), 32'd0);

        // Key 2 press then clean release
        bus.key_in[2] = 1'b0;
        expect_press(4'b0100, 4'b0100, 3'd2);
        repeat (20) @(negedge clk);
        bus.key_in[2] = 1'b1;
        expect_release(4'b0100, 4'b0000);
        repeat (20) @(negedge clk);
        chk("t3_level", 32'(bus.key_level), 32'd0);

        // Keys 3 and 1 together: code reports lowest index
        bus.key_in[3] = 1'b0;
        bus.key_in[1] = 1'b0;
        expect_press(4'b1010, 4'b1010, 3'd1);
        repeat (20) @(negedge clk);
        bus.key_in = '1;
        expect_release(4'b1010, 4'b0000);
        repeat (20) @(negedge clk);
        chk("t4_code_hold", 32'(bus.key_event_code), 32'd1);

        // Key 0 held, short release bounce must not release it
        bus.key_in[0] = 1'b0;
        expect_press(4'b0001, 4'b0001, 3'd0);
        repeat (20) @(negedge clk);
        bus.key_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        bus.key_in[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_level", 32'(bus.key_level), 32'h1);

        // Reset while DOWN: immediate clear, no release pulse
        #2 rst_n = 1'b0;
        #1;
        chk("rst_down_level", 32'(bus.key_level), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Key still held: reset again mid-filter (counter at 5)
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_filt_level", 32'(bus.key_level), 32'd0);
        chk("rst_filt_press", 32'(bus.key_press), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_press(4'b0001, 4'b0001, 3'd0);
        repeat (20) @(negedge clk);
        chk("t5_level", 32'(bus.key_level), 32'h1);
        bus.key_in[0] = 1'b1;
        expect_release(4'b0001, 4'b0000);
        repeat (20) @(negedge clk);

        repeat (5) @(negedge clk);
        chk("pending_pulses", 32'(pq.size()), 32'd0);
        chk("pending_events", 32'(eq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
